// File: rtl/time_of_day_if.sv
// Bundle between the time-of-day core and its neighbours: front-panel
// adjust requests in, 1 Hz tick, end-of-day flag and current time out.
interface time_of_day_if;
    logic       inc_hour;
    logic       inc_minute;
    logic       clear_seconds;
    logic       tick_1Hz;
    logic       end_of_day;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;

    modport master (
        input  inc_hour, inc_minute, clear_seconds,
        output tick_1Hz, end_of_day, hour, minute, second
    );

    modport slave (
        output inc_hour, inc_minute, clear_seconds,
        input  tick_1Hz, end_of_day, hour, minute, second
    );
endinterface

// File: rtl/time_of_day_counter.sv
// Divides the system clock to a 1 Hz tick and keeps hh:mm:ss, with
// synchronized front-panel hour/minute adjust and seconds clear.
module time_of_day_counter #(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int DEFAULT_HOUR   = 0,
    parameter int DEFAULT_MINUTE = 0,
    parameter int DEFAULT_SECOND = 0
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    time_of_day_if.master bus
);
    localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ_HZ - 1);
    localparam logic [7:0] DEF_HR  = 8'(DEFAULT_HOUR);
    localparam logic [7:0] DEF_MIN = 8'(DEFAULT_MINUTE);
    localparam logic [7:0] DEF_SEC = 8'(DEFAULT_SECOND);
    localparam logic DEF_EOD = (DEFAULT_HOUR == 23) && (DEFAULT_MINUTE == 59) &&
                               (DEFAULT_SECOND == 59);

    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max_v);
        return (v == max_v) ? 8'd0 : v + 8'd1;
    endfunction

    // bit 0 = inc_hour, bit 1 = inc_minute, bit 2 = clear_seconds
    logic [2:0]    btn_s;
    logic [2:0]    meta_r, sync_r, prev_r;
    logic [2:0]    ev_s;
    logic [PW-1:0] presc_r;
    logic          tick_r, eod_r;
    logic [7:0]    hr_r, min_r, sec_r;
    logic          pend_hr_r, pend_min_r;
    logic [7:0]    hr_n_s, min_n_s, sec_n_s;
    logic          pend_hr_n_s, pend_min_n_s;
    logic          hr_req_s, min_req_s, adv_s, clr_ev_s;

    assign btn_s     = {bus.clear_seconds, bus.inc_minute, bus.inc_hour};
    assign ev_s      = sync_r & ~prev_r;
    assign clr_ev_s  = ev_s[2];
    assign hr_req_s  = ev_s[0] | pend_hr_r;
    assign min_req_s = ev_s[1] | pend_min_r;
    // A clear cancels the advance outright, so it never carries.
    assign adv_s     = tick_r & ~clr_ev_s;

    // Next-state time; a manual adjust colliding with an advance is parked for one edge.
    always_comb begin
        sec_n_s      = sec_r;
        min_n_s      = min_r;
        hr_n_s       = hr_r;
        pend_hr_n_s  = 1'b0;
        pend_min_n_s = 1'b0;
        if (clr_ev_s) begin
            sec_n_s = 8'd0;
        end else if (adv_s) begin
            sec_n_s = wrap_inc(sec_r, 8'd59);
            if (sec_r == 8'd59) begin
                min_n_s = wrap_inc(min_r, 8'd59);
                if (min_r == 8'd59) begin
                    hr_n_s = wrap_inc(hr_r, 8'd23);
                end else begin
                    hr_n_s = hr_r;
                end
            end else begin
                min_n_s = min_r;
            end
        end else begin
            sec_n_s = sec_r;
        end
        if (adv_s) begin
            pend_hr_n_s  = hr_req_s;
            pend_min_n_s = min_req_s;
        end else begin
            if (min_req_s) begin
                min_n_s = wrap_inc(min_r, 8'd59);
            end else begin
                min_n_s = min_n_s;
            end
            if (hr_req_s) begin
                hr_n_s = wrap_inc(hr_r, 8'd23);
            end else begin
                hr_n_s = hr_n_s;
            end
        end
    end

    // Button synchronizers, prescaler, tick and time registers.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            meta_r     <= 3'b000;
            sync_r     <= 3'b000;
            prev_r     <= 3'b000;
            presc_r    <= '0;
            tick_r     <= 1'b0;
            hr_r       <= DEF_HR;
            min_r      <= DEF_MIN;
            sec_r      <= DEF_SEC;
            eod_r      <= DEF_EOD;
            pend_hr_r  <= 1'b0;
            pend_min_r <= 1'b0;
        end else begin
            meta_r <= btn_s;
            sync_r <= meta_r;
            prev_r <= sync_r;
            if (clr_ev_s) begin
                presc_r <= '0;
                tick_r  <= 1'b0;
            end else if (presc_r == PRESC_TC) begin
                presc_r <= '0;
                tick_r  <= 1'b1;
            end else begin
                presc_r <= presc_r + PW'(1);
                tick_r  <= 1'b0;
            end
            hr_r       <= hr_n_s;
            min_r      <= min_n_s;
            sec_r      <= sec_n_s;
            pend_hr_r  <= pend_hr_n_s;
            pend_min_r <= pend_min_n_s;
            eod_r      <= (hr_n_s == 8'd23) && (min_n_s == 8'd59) && (sec_n_s == 8'd59);
        end
    end

    assign bus.tick_1Hz   = tick_r;
    assign bus.end_of_day = eod_r;
    assign bus.hour       = hr_r;
    assign bus.minute     = min_r;
    assign bus.second     = sec_r;
endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with a 10-cycle second.
module tb_time_of_day_counter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   eod_tick_cnt = 0;

    time_of_day_if tod();

    time_of_day_counter #(
        .CLK_FREQ_HZ(10), .DEFAULT_HOUR(0), .DEFAULT_MINUTE(0), .DEFAULT_SECOND(0)
    ) dut (
        .clk_100MHz(clk),
        .reset(reset),
        .bus(tod)
    );

    always #5 clk = ~clk;

    // Calendar-side view: end_of_day seen while the tick is high.
    always @(negedge clk) begin
        if (tod.tick_1Hz && tod.end_of_day) eod_tick_cnt <= eod_tick_cnt + 1;
    end

    typedef struct {
        int   k;
        logic tick;
        int   sec;
    } vec_t;

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s);
        chk(name, int'(tod.hour) * 10000 + int'(tod.minute) * 100 + int'(tod.second),
            h * 10000 + m * 100 + s);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: tod.inc_hour = v;
            1: tod.inc_minute = v;
            default: tod.clear_seconds = v;
        endcase
    endtask

    task automatic press(input int which);
        set_btn(which, 1'b1);
        step_n(2);
        set_btn(which, 1'b0);
        step_n(2);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step_n(2);
        reset = 1'b0;
    endtask

    // Leaves the counter at h:m:s with the prescaler at 1.
    task automatic set_time(input int h, input int m, input int s);
        do_reset();
        repeat (h) press(0);
        repeat (m) press(1);
        press(2);
        step_n(10 * s);
    endtask

    vec_t vecs[9];
    int   k_now;
    int   base;

    initial begin
        tod.inc_hour = 1'b0;
        tod.inc_minute = 1'b0;
        tod.clear_seconds = 1'b0;
        vecs[0] = '{1, 1'b0, 0};
        vecs[1] = '{9, 1'b0, 0};
        vecs[2] = '{10, 1'b1, 0};
        vecs[3] = '{11, 1'b0, 1};
        vecs[4] = '{20, 1'b1, 1};
        vecs[5] = '{21, 1'b0, 2};
        vecs[6] = '{30, 1'b1, 2};
        vecs[7] = '{31, 1'b0, 3};
        vecs[8] = '{35, 1'b0, 3};

        // Reset state and free-running seconds
        step_n(2);
        chk_time("reset_time", 0, 0, 0);
        chk("reset_tick", tod.tick_1Hz, 0);
        chk("reset_eod", tod.end_of_day, 0);
        reset = 1'b0;
        k_now = 0;
        for (int i = 0; i < 9; i++) begin
            step_n(vecs[i].k - k_now);
            k_now = vecs[i].k;
            chk($sformatf("run_tick_k%0d", vecs[i].k), tod.tick_1Hz, vecs[i].tick);
            chk($sformatf("run_sec_k%0d", vecs[i].k), tod.second, vecs[i].sec);
        end
        chk_time("run_time_k35", 0, 0, 3);

        // Midnight rollover
        set_time(23, 59, 58);
        chk_time("eod_pre", 23, 59, 58);
        step_n(9);
        chk("eod_t1_tick", tod.tick_1Hz, 1);
        chk("eod_t1_eod", tod.end_of_day, 0);
        step_n(1);
        chk_time("eod_2359", 23, 59, 59);
        chk("eod_high", tod.end_of_day, 1);
        step_n(9);
        chk("eod_t2_tick", tod.tick_1Hz, 1);
        chk("eod_at_tick", tod.end_of_day, 1);
        step_n(1);
        chk_time("eod_wrap", 0, 0, 0);
        chk("eod_low", tod.end_of_day, 0);

        // Held inc_minute: one increment, no hour carry
        set_time(0, 59, 30);
        tod.inc_minute = 1'b1;
        step_n(2);
        chk("minhold_lat2", tod.minute, 59);
        step_n(1);
        chk_time("minhold_lat3", 0, 0, 30);
        step_n(47);
        chk_time("minhold_50", 0, 0, 35);
        tod.inc_minute = 1'b0;
        step_n(3);
        chk("minhold_rel", tod.minute, 0);

        // inc_hour colliding with the midnight advance
        set_time(23, 59, 58);
        base = eod_tick_cnt;
        step_n(17);
        tod.inc_hour = 1'b1;
        step_n(3);
        chk_time("hr_coll_adv", 0, 0, 0);
        step_n(1);
        chk_time("hr_coll_defer", 1, 0, 0);
        tod.inc_hour = 1'b0;
        step_n(3);
        chk("hr_coll_eodticks", eod_tick_cnt - base, 1);
        chk("hr_coll_hour", tod.hour, 1);

        // clear_seconds on the tick at 12:34:59
        set_time(12, 34, 58);
        step_n(17);
        tod.clear_seconds = 1'b1;
        step_n(3);
        chk_time("clr_coll", 12, 34, 0);
        tod.clear_seconds = 1'b0;
        step_n(9);
        chk("clr_no_tick9", tod.tick_1Hz, 0);
        step_n(1);
        chk("clr_tick10", tod.tick_1Hz, 1);
        step_n(1);
        chk_time("clr_after", 12, 34, 1);

        // Async reset mid-second
        set_time(5, 6, 7);
        step_n(5);
        chk_time("areset_pre", 5, 6, 7);
        #2;
        reset = 1'b1;
        #1;
        chk_time("areset_now", 0, 0, 0);
        chk("areset_tick", tod.tick_1Hz, 0);
        chk("areset_eod", tod.end_of_day, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step_n(9);
        chk("areset_no_tick9", tod.tick_1Hz, 0);
        step_n(1);
        chk("areset_tick10", tod.tick_1Hz, 1);
        chk("areset_sec", tod.second, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
